// File: rtl/tod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tod_counter
//  Purpose  : BCD time-of-day counter, HH:MM:SS, selectable 12/24-hour format,
//             range-checked time load, minute/hour adjust and N independent
//             alarm comparators. Advances on a 1 Hz tick enable.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    H24       1 = 24-hour (00-23), 0 = 12-hour (01-12) with pm flag
//    N_ALARM   number of alarm channels (1-8)
//    AW        alarm index width
//  Ports
//    clk        system clock
//    rst        asynchronous active-low reset
//    tick       1 Hz enable, one clk wide
//    run        1 = timekeeping, 0 = adjust mode
//    adj_sel    01 = minutes, 10 = hours, others = none
//    adj_inc    one-cycle increment of the selected field (adjust mode)
//    load       one-cycle request to load load_time / load_pm
//    load_time  BCD time [21:20] hr tens .. [3:0] sec ones
//    load_pm    pm value for a load (12-hour only)
//    alarm_wr   one-cycle alarm write of alarm_time/alarm_pm to alarm_idx
//    alarm_idx  alarm channel index
//    alarm_time alarm HH:MM in the layout of count[21:8]
//    alarm_pm   alarm pm value (12-hour only)
//    alarm_en   per-channel arm level
//    count      current time, BCD
//    pm         pm flag (always 0 in 24-hour format)
//    min_tick   pulse on seconds 59 -> 00
//    day_tick   pulse on day wrap
//    alarm_hit  per-channel alarm match pulse
//    cfg_err    pulse on a rejected load or alarm write
// ============================================================================
module tod_counter #(
    parameter int H24     = 1,
    parameter int N_ALARM = 2,
    parameter int AW      = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               run,
    input  logic [1:0]         adj_sel,
    input  logic               adj_inc,
    input  logic               load,
    input  logic [21:0]        load_time,
    input  logic               load_pm,
    input  logic               alarm_wr,
    input  logic [AW-1:0]      alarm_idx,
    input  logic [13:0]        alarm_time,
    input  logic               alarm_pm,
    input  logic [N_ALARM-1:0] alarm_en,
    output logic [21:0]        count,
    output logic               pm,
    output logic               min_tick,
    output logic               day_tick,
    output logic [N_ALARM-1:0] alarm_hit,
    output logic               cfg_err
);

    // Midnight is 00 in 24-hour format and 12 (am) in 12-hour format.
    localparam logic [5:0]  C_RESET_HR   = (H24 != 0) ? 6'h00 : 6'h12;
    localparam logic [21:0] C_RESET_TIME = {C_RESET_HR, 16'h0000};
    localparam logic [13:0] C_ALARM_RST  = {C_RESET_HR, 8'h00};
    localparam logic [1:0]  C_SEL_MIN    = 2'b01;
    localparam logic [1:0]  C_SEL_HR     = 2'b10;

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------

    // Hour field legal for the selected format.
    function automatic logic hour_ok(input logic [5:0] hr);
        logic ok;
        if (hr[3:0] > 4'd9) begin
            ok = 1'b0;
        end else if (H24 != 0) begin
            ok = (hr[5:4] < 2'd2) || ((hr[5:4] == 2'd2) && (hr[3:0] <= 4'd3));
        end else begin
            ok = ((hr[5:4] == 2'd0) && (hr[3:0] != 4'd0)) ||
                 ((hr[5:4] == 2'd1) && (hr[3:0] <= 4'd2));
        end
        return ok;
    endfunction

    // Minute or second field legal (00-59).
    function automatic logic sixty_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    // Next value of a 00-59 BCD field, wrapping 59 -> 00.
    function automatic logic [7:0] sixty_inc(input logic [7:0] v);
        logic [7:0] n;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) begin
                n = 8'h00;
            end else begin
                n = {v[7:4] + 4'd1, 4'h0};
            end
        end else begin
            n = {v[7:4], v[3:0] + 4'd1};
        end
        return n;
    endfunction

    // Next hour. Result packs {day_wrap, pm_next, hour_next}.
    // In 12-hour format the pm flag flips on 11 -> 12; the day wraps only
    // when that flip is pm -> am (midnight).
    function automatic logic [7:0] hour_inc(input logic [5:0] hr, input logic pm_in);
        logic [5:0] h;
        logic       p;
        logic       d;
        h = hr;
        p = pm_in;
        d = 1'b0;
        if (H24 != 0) begin
            if (hr == 6'h23) begin
                h = 6'h00;
                d = 1'b1;
            end else if (hr[3:0] == 4'd9) begin
                h = {hr[5:4] + 2'd1, 4'h0};
            end else begin
                h = {hr[5:4], hr[3:0] + 4'd1};
            end
        end else begin
            if (hr == 6'h11) begin
                h = 6'h12;
                p = ~pm_in;
                d = pm_in;
            end else if (hr == 6'h12) begin
                h = 6'h01;
            end else if (hr[3:0] == 4'd9) begin
                h = 6'h10;
            end else begin
                h = {hr[5:4], hr[3:0] + 4'd1};
            end
        end
        return {d, p, h};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [21:0]        r_count;
    logic               r_pm;
    logic               r_min_tick;
    logic               r_day_tick;
    logic [N_ALARM-1:0] r_alarm_hit;
    logic               r_cfg_err;
    logic [13:0]        r_alarm_time [N_ALARM];
    logic               r_alarm_pm   [N_ALARM];

    // ------------------------------------------------------------------
    // Field increments of the current time
    // ------------------------------------------------------------------
    logic [7:0] w_sec_inc;
    logic [7:0] w_min_inc;
    logic [7:0] w_hr_inc;
    logic       w_load_ok;
    logic       w_alarm_ok;

    assign w_sec_inc  = sixty_inc(r_count[7:0]);
    assign w_min_inc  = sixty_inc(r_count[15:8]);
    assign w_hr_inc   = hour_inc(r_count[21:16], r_pm);

    assign w_load_ok  = hour_ok(load_time[21:16]) &&
                        sixty_ok(load_time[15:8]) &&
                        sixty_ok(load_time[7:0]);

    assign w_alarm_ok = hour_ok(alarm_time[13:8]) &&
                        sixty_ok(alarm_time[7:0]) &&
                        (int'(alarm_idx) < N_ALARM);

    // ------------------------------------------------------------------
    // Next-state: load > run-mode tick > adjust increment
    // ------------------------------------------------------------------
    logic [21:0]        w_nxt_count;
    logic               w_nxt_pm;
    logic               w_nxt_min;
    logic               w_nxt_day;
    logic               w_tick_evt;
    logic               w_nxt_err;
    logic [N_ALARM-1:0] w_nxt_hit;

    always_comb begin
        w_nxt_count = r_count;
        w_nxt_pm    = r_pm;
        w_nxt_min   = 1'b0;
        w_nxt_day   = 1'b0;
        w_tick_evt  = 1'b0;

        if (load) begin
            // A rejected load still consumes the cycle: any tick is dropped.
            if (w_load_ok) begin
                w_nxt_count = load_time;
                w_nxt_pm    = (H24 != 0) ? 1'b0 : load_pm;
            end
        end else if (run) begin
            if (tick) begin
                w_tick_evt         = 1'b1;
                w_nxt_count[7:0]   = w_sec_inc;
                if (r_count[7:0] == 8'h59) begin
                    w_nxt_min          = 1'b1;
                    w_nxt_count[15:8]  = w_min_inc;
                    if (r_count[15:8] == 8'h59) begin
                        w_nxt_count[21:16] = w_hr_inc[5:0];
                        w_nxt_pm           = w_hr_inc[6];
                        w_nxt_day          = w_hr_inc[7];
                    end
                end
            end
        end else if (adj_inc) begin
            // Adjust never carries between fields and never emits ticks.
            if (adj_sel == C_SEL_MIN) begin
                w_nxt_count[15:8] = w_min_inc;
            end else if (adj_sel == C_SEL_HR) begin
                w_nxt_count[21:16] = w_hr_inc[5:0];
                w_nxt_pm           = w_hr_inc[6];
            end
        end
    end

    // Both rejections in one cycle still produce a single pulse.
    assign w_nxt_err = (load && !w_load_ok) || (alarm_wr && !w_alarm_ok);

    // Alarm compare uses the pre-write channel contents, so a write takes
    // effect for matches from the following edge.
    for (genvar gi = 0; gi < N_ALARM; gi++) begin : g_alarm_cmp
        assign w_nxt_hit[gi] = w_tick_evt && alarm_en[gi] &&
                               (w_nxt_count == {r_alarm_time[gi], 8'h00}) &&
                               ((H24 != 0) || (w_nxt_pm == r_alarm_pm[gi]));
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count     <= C_RESET_TIME;
            r_pm        <= 1'b0;
            r_min_tick  <= 1'b0;
            r_day_tick  <= 1'b0;
            r_alarm_hit <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_count     <= w_nxt_count;
            r_pm        <= w_nxt_pm;
            r_min_tick  <= w_nxt_min;
            r_day_tick  <= w_nxt_day;
            r_alarm_hit <= w_nxt_hit;
            r_cfg_err   <= w_nxt_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_ALARM; i++) begin
                r_alarm_time[i] <= C_ALARM_RST;
                r_alarm_pm[i]   <= 1'b0;
            end
        end else if (alarm_wr && w_alarm_ok) begin
            for (int i = 0; i < N_ALARM; i++) begin
                if (alarm_idx == AW'(i)) begin
                    r_alarm_time[i] <= alarm_time;
                    r_alarm_pm[i]   <= (H24 != 0) ? 1'b0 : alarm_pm;
                end
            end
        end
    end

    assign count     = r_count;
    assign pm        = r_pm;
    assign min_tick  = r_min_tick;
    assign day_tick  = r_day_tick;
    assign alarm_hit = r_alarm_hit;
    assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_tod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tod_counter
//  Purpose  : Directed table-driven bench for tod_counter. Two instances share
//             the stimulus: a 24-hour counter with 3 alarm channels and a
//             12-hour counter with 2 alarm channels.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tod_counter;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        run;
    logic [1:0]  adj_sel;
    logic        adj_inc;
    logic        load;
    logic [21:0] load_time;
    logic        load_pm;
    logic        alarm_wr;
    logic [1:0]  alarm_idx;
    logic [13:0] alarm_time;
    logic        alarm_pm;
    logic [2:0]  alarm_en;

    logic [21:0] cnt24;
    logic        pm24;
    logic        min24;
    logic        day24;
    logic [2:0]  hit24;
    logic        err24;

    logic [21:0] cnt12;
    logic        pm12;
    logic        min12;
    logic        day12;
    logic [1:0]  hit12;
    logic        err12;

    tod_counter #(.H24(1), .N_ALARM(3)) dut24 (
        .clk(clk), .rst(rst), .tick(tick), .run(run),
        .adj_sel(adj_sel), .adj_inc(adj_inc),
        .load(load), .load_time(load_time), .load_pm(load_pm),
        .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_time(alarm_time),
        .alarm_pm(alarm_pm), .alarm_en(alarm_en),
        .count(cnt24), .pm(pm24), .min_tick(min24), .day_tick(day24),
        .alarm_hit(hit24), .cfg_err(err24)
    );

    tod_counter #(.H24(0), .N_ALARM(2)) dut12 (
        .clk(clk), .rst(rst), .tick(tick), .run(run),
        .adj_sel(adj_sel), .adj_inc(adj_inc),
        .load(load), .load_time(load_time), .load_pm(load_pm),
        .alarm_wr(alarm_wr), .alarm_idx(alarm_idx[0:0]), .alarm_time(alarm_time),
        .alarm_pm(alarm_pm), .alarm_en(alarm_en[1:0]),
        .count(cnt12), .pm(pm12), .min_tick(min12), .day_tick(day12),
        .alarm_hit(hit12), .cfg_err(err12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        c12;
        logic        ld;
        logic [21:0] lt;
        logic        lpm;
        logic        rn;
        logic        tk;
        logic [1:0]  asel;
        logic        ainc;
        logic        awr;
        logic [1:0]  aidx;
        logic [13:0] at;
        logic        apm;
        logic [2:0]  aen;
        logic [21:0] e_cnt;
        logic        e_pm;
        logic        e_min;
        logic        e_day;
        logic        e_err;
        logic [2:0]  e_hit;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void add(
        input logic c12, input logic ld, input logic [21:0] lt, input logic lpm,
        input logic rn, input logic tk, input logic [1:0] asel, input logic ainc,
        input logic awr, input logic [1:0] aidx, input logic [13:0] at, input logic apm,
        input logic [2:0] aen,
        input logic [21:0] e_cnt, input logic e_pm, input logic e_min,
        input logic e_day, input logic e_err, input logic [2:0] e_hit);
        vec_t v;
        v.c12 = c12; v.ld = ld; v.lt = lt; v.lpm = lpm; v.rn = rn; v.tk = tk;
        v.asel = asel; v.ainc = ainc; v.awr = awr; v.aidx = aidx; v.at = at;
        v.apm = apm; v.aen = aen; v.e_cnt = e_cnt; v.e_pm = e_pm;
        v.e_min = e_min; v.e_day = e_day; v.e_err = e_err; v.e_hit = e_hit;
        vecs.push_back(v);
    endfunction

    task automatic idle_inputs();
        tick = 0; adj_sel = 2'b00; adj_inc = 0; load = 0; load_time = '0;
        load_pm = 0; alarm_wr = 0; alarm_idx = '0; alarm_time = '0;
        alarm_pm = 0; alarm_en = '0;
    endtask

    initial begin
        rst = 1'b0;
        run = 1'b0;
        idle_inputs();

        // 24-hour instance, c12=0
        //   c12 ld lt        lpm rn tk asel ai aw idx at       apm aen      e_cnt     pm mn dy er hit
        add(0, 1, 'h235958, 1, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h235958, 0, 0, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 1, 1, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h235959, 0, 0, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 1, 1, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h000000, 0, 1, 1, 0, 3'b000);
        add(0, 0, 'h000000, 0, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h000000, 0, 0, 0, 0, 3'b000);
        add(0, 1, 'h240000, 0, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h000000, 0, 0, 0, 1, 3'b000);
        add(0, 0, 'h000000, 0, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h000000, 0, 0, 0, 0, 3'b000);
        add(0, 1, 'h126000, 0, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h000000, 0, 0, 0, 1, 3'b000);
        add(0, 1, 'h105930, 0, 0, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h105930, 0, 0, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 0, 0, 2'b01, 1, 0, 0, 'h0000, 0, 3'b000, 'h100030, 0, 0, 0, 0, 3'b000);
        add(0, 1, 'h230030, 0, 0, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h230030, 0, 0, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 0, 0, 2'b10, 1, 0, 0, 'h0000, 0, 3'b000, 'h000030, 0, 0, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 0, 1, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h000030, 0, 0, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 0, 1, 2'b01, 1, 0, 0, 'h0000, 0, 3'b000, 'h000130, 0, 0, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 0, 0, 2'b11, 1, 0, 0, 'h0000, 0, 3'b000, 'h000130, 0, 0, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 0, 0, 2'b00, 0, 1, 0, 'h0730, 0, 3'b000, 'h000130, 0, 0, 0, 0, 3'b000);
        add(0, 1, 'h072959, 0, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b001, 'h072959, 0, 0, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 1, 1, 2'b00, 0, 0, 0, 'h0000, 0, 3'b001, 'h073000, 0, 1, 0, 0, 3'b001);
        add(0, 1, 'h072959, 0, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h072959, 0, 0, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 1, 1, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h073000, 0, 1, 0, 0, 3'b000);
        add(0, 1, 'h073000, 0, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b001, 'h073000, 0, 0, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 1, 0, 2'b00, 0, 1, 3, 'h0800, 0, 3'b000, 'h073000, 0, 0, 0, 1, 3'b000);
        add(0, 0, 'h000000, 0, 1, 0, 2'b00, 0, 1, 1, 'h2500, 0, 3'b000, 'h073000, 0, 0, 0, 1, 3'b000);
        add(0, 1, 'h1A0000, 0, 1, 0, 2'b00, 0, 1, 1, 'h0731, 0, 3'b000, 'h073000, 0, 0, 0, 1, 3'b000);
        add(0, 0, 'h000000, 0, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h073000, 0, 0, 0, 0, 3'b000);
        add(0, 1, 'h073059, 0, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b011, 'h073059, 0, 0, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 1, 1, 2'b00, 0, 0, 0, 'h0000, 0, 3'b011, 'h073100, 0, 1, 0, 0, 3'b010);
        add(0, 1, 'h080059, 0, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b100, 'h080059, 0, 0, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 1, 1, 2'b00, 0, 1, 2, 'h0801, 0, 3'b100, 'h080100, 0, 1, 0, 0, 3'b000);
        add(0, 1, 'h080059, 0, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b100, 'h080059, 0, 0, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 1, 1, 2'b00, 0, 0, 0, 'h0000, 0, 3'b100, 'h080100, 0, 1, 0, 0, 3'b100);
        add(0, 1, 'h123456, 0, 1, 1, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h123456, 0, 0, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 1, 1, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h123457, 0, 0, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 1, 1, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h123458, 0, 0, 0, 0, 3'b000);
        add(0, 1, 'h195959, 0, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h195959, 0, 0, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 1, 1, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h200000, 0, 1, 0, 0, 3'b000);
        add(0, 1, 'h095959, 0, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h095959, 0, 0, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 1, 1, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h100000, 0, 1, 0, 0, 3'b000);
        add(0, 0, 'h000000, 0, 1, 0, 2'b01, 1, 0, 0, 'h0000, 0, 3'b000, 'h100000, 0, 0, 0, 0, 3'b000);
        // 12-hour instance, c12=1
        add(1, 1, 'h115959, 0, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h115959, 0, 0, 0, 0, 3'b000);
        add(1, 0, 'h000000, 0, 1, 1, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h120000, 1, 1, 0, 0, 3'b000);
        add(1, 1, 'h125959, 1, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h125959, 1, 0, 0, 0, 3'b000);
        add(1, 0, 'h000000, 0, 1, 1, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h010000, 1, 1, 0, 0, 3'b000);
        add(1, 1, 'h115959, 1, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h115959, 1, 0, 0, 0, 3'b000);
        add(1, 0, 'h000000, 0, 1, 1, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h120000, 0, 1, 1, 0, 3'b000);
        add(1, 1, 'h000000, 1, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h120000, 0, 0, 0, 1, 3'b000);
        add(1, 1, 'h130000, 1, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h120000, 0, 0, 0, 1, 3'b000);
        add(1, 1, 'h111500, 0, 0, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b000, 'h111500, 0, 0, 0, 0, 3'b000);
        add(1, 0, 'h000000, 0, 0, 0, 2'b10, 1, 0, 0, 'h0000, 0, 3'b000, 'h121500, 1, 0, 0, 0, 3'b000);
        add(1, 0, 'h000000, 0, 0, 0, 2'b10, 1, 0, 0, 'h0000, 0, 3'b000, 'h011500, 1, 0, 0, 0, 3'b000);
        add(1, 0, 'h000000, 0, 0, 0, 2'b00, 0, 1, 0, 'h0600, 1, 3'b000, 'h011500, 1, 0, 0, 0, 3'b000);
        add(1, 1, 'h055959, 0, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b001, 'h055959, 0, 0, 0, 0, 3'b000);
        add(1, 0, 'h000000, 0, 1, 1, 2'b00, 0, 0, 0, 'h0000, 0, 3'b001, 'h060000, 0, 1, 0, 0, 3'b000);
        add(1, 1, 'h055959, 1, 1, 0, 2'b00, 0, 0, 0, 'h0000, 0, 3'b001, 'h055959, 1, 0, 0, 0, 3'b000);
        add(1, 0, 'h000000, 0, 1, 1, 2'b00, 0, 0, 0, 'h0000, 0, 3'b001, 'h060000, 1, 1, 0, 0, 3'b001);

        // Reset state, both while held and after release
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt24", 32'(cnt24), 32'h000000);
        chk("rst_cnt12", 32'(cnt12), 32'h120000);
        chk("rst_pm12", 32'(pm12), 0);
        chk("rst_pulses24", 32'({min24, day24, hit24, err24}), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_cnt24", 32'(cnt24), 32'h000000);
        chk("rel_pulses12", 32'({min12, day12, hit12, err12}), 0);

        // Table
        for (int i = 0; i < vecs.size(); i++) begin
            load = vecs[i].ld; load_time = vecs[i].lt; load_pm = vecs[i].lpm;
            run = vecs[i].rn; tick = vecs[i].tk; adj_sel = vecs[i].asel;
            adj_inc = vecs[i].ainc; alarm_wr = vecs[i].awr; alarm_idx = vecs[i].aidx;
            alarm_time = vecs[i].at; alarm_pm = vecs[i].apm; alarm_en = vecs[i].aen;
            @(posedge clk);
            #1;
            if (vecs[i].c12) begin
                chk($sformatf("row%0d_cnt12", i), 32'(cnt12), 32'(vecs[i].e_cnt));
                chk($sformatf("row%0d_pm12", i), 32'(pm12), 32'(vecs[i].e_pm));
                chk($sformatf("row%0d_min12", i), 32'(min12), 32'(vecs[i].e_min));
                chk($sformatf("row%0d_day12", i), 32'(day12), 32'(vecs[i].e_day));
                chk($sformatf("row%0d_err12", i), 32'(err12), 32'(vecs[i].e_err));
                chk($sformatf("row%0d_hit12", i), 32'(hit12), 32'(vecs[i].e_hit));
            end else begin
                chk($sformatf("row%0d_cnt24", i), 32'(cnt24), 32'(vecs[i].e_cnt));
                chk($sformatf("row%0d_pm24", i), 32'(pm24), 32'(vecs[i].e_pm));
                chk($sformatf("row%0d_min24", i), 32'(min24), 32'(vecs[i].e_min));
                chk($sformatf("row%0d_day24", i), 32'(day24), 32'(vecs[i].e_day));
                chk($sformatf("row%0d_err24", i), 32'(err24), 32'(vecs[i].e_err));
                chk($sformatf("row%0d_hit24", i), 32'(hit24), 32'(vecs[i].e_hit));
            end
        end
        idle_inputs();

        // Reset mid-operation with a pulse pending
        run = 1; load = 1; load_time = 22'h154217;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("mid_cnt24", 32'(cnt24), 32'h154217);
        alarm_wr = 1; alarm_idx = 2'd3; alarm_time = 14'h0800;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("mid_err24", 32'(err24), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_cnt24", 32'(cnt24), 32'h000000);
        chk("async_err24", 32'(err24), 0);
        chk("async_cnt12", 32'(cnt12), 32'h120000);
        chk("async_pm12", 32'(pm12), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rel_cnt24", 32'(cnt24), 32'h000000);
        chk("post_rel_pulses24", 32'({min24, day24, hit24, err24}), 0);
        tick = 1;
        @(posedge clk);
        #1;
        tick = 0;
        chk("post_rel_tick24", 32'(cnt24), 32'h000001);
        chk("post_rel_tick12", 32'(cnt12), 32'h120001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
